// File: rtl/i2s_stream_controller_pkg.sv
// Shared types and constants for the I2S stream controller: fetch FSM encoding,
// counter widths and the channel-index width helper.
package i2s_stream_controller_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_t;

  localparam int UNDERRUN_CNT_W = 16;
  localparam int REQ_SIZE_W     = 24;

  // A single channel still needs a 1-bit index port.
  function automatic int ch_width(input int channels);
    return (channels <= 1) ? 1 : $clog2(channels);
  endfunction

endpackage

// File: rtl/i2s_stream_controller_if.sv
// Bundles the memory-fetch side, the I2S writer handshake and the status
// outputs of the stream controller into one port.
interface i2s_stream_controller_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int SAMPLE_WIDTH    = 24,
  parameter int CHANNELS        = 2,
  parameter int FIFO_ADDR_WIDTH = 4
);
  import i2s_stream_controller_pkg::*;

  localparam int CH_W = ch_width(CHANNELS);

  logic                      enable;
  logic                      flush;
  logic                      hold_on_underrun;
  logic                      request_data;
  logic [REQ_SIZE_W-1:0]     request_size;
  logic                      request_finished;
  logic                      memory_data_strobe;
  logic [DATA_WIDTH-1:0]     memory_data;
  // Writer handshake is 4-phase: request rises, ack rises with data valid,
  // request falls, ack falls; data/channel then hold until the next ack.
  logic                      audio_data_request;
  logic                      audio_data_ack;
  logic [SAMPLE_WIDTH-1:0]   audio_data;
  logic [CH_W-1:0]           audio_channel;
  logic                      underrun;
  logic                      overflow;
  logic [UNDERRUN_CNT_W-1:0] underrun_count;
  logic [FIFO_ADDR_WIDTH:0]  fifo_level;
  fetch_state_t              fetch_state;

  modport master (
    input  enable, flush, hold_on_underrun, request_finished,
           memory_data_strobe, memory_data, audio_data_request,
    output request_data, request_size, audio_data_ack, audio_data,
           audio_channel, underrun, overflow, underrun_count, fifo_level,
           fetch_state
  );

  modport slave (
    output enable, flush, hold_on_underrun, request_finished,
           memory_data_strobe, memory_data, audio_data_request,
    input  request_data, request_size, audio_data_ack, audio_data,
           audio_channel, underrun, overflow, underrun_count, fifo_level,
           fetch_state
  );

endinterface

// File: rtl/i2s_stream_controller_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with flush and a registered level.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module i2s_stream_controller_sync_fifo #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_level
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full    = (r_level == DEPTH_L);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push && !rst && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_stream_controller.sv
// Fetches sample bursts from memory into a FIFO and serves them to an I2S
// writer with N-channel sequencing, underrun fill and overflow/underrun status.
module i2s_stream_controller
  import i2s_stream_controller_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int SAMPLE_WIDTH    = 24,
  parameter int CHANNELS        = 2,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int BURST_SIZE      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  i2s_stream_controller_if.master bus
);

  localparam int CH_W  = ch_width(CHANNELS);
  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_L = (FIFO_ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [FIFO_ADDR_WIDTH:0] BURST_L = (FIFO_ADDR_WIDTH + 1)'(BURST_SIZE);
  localparam logic [CH_W-1:0]          LAST_CH = CH_W'(CHANNELS - 1);

  if (SAMPLE_WIDTH > DATA_WIDTH) begin : g_bad_width
    $error("SAMPLE_WIDTH must not exceed DATA_WIDTH");
  end

  fetch_state_t              r_state;
  logic                      r_request_data;
  logic [REQ_SIZE_W-1:0]     r_request_size;
  logic                      r_ack;
  logic [SAMPLE_WIDTH-1:0]   r_audio_data;
  logic [SAMPLE_WIDTH-1:0]   r_last_sample;
  logic [CH_W-1:0]           r_channel;
  logic [CH_W-1:0]           r_ch_cnt;
  logic                      r_underrun;
  logic                      r_overflow;
  logic [UNDERRUN_CNT_W-1:0] r_underrun_count;
  logic [SAMPLE_WIDTH-1:0]   w_head;
  logic                      w_full;
  logic                      w_empty;
  logic [FIFO_ADDR_WIDTH:0]  w_level;
  logic                      w_trigger;
  logic                      w_pop;
  logic                      w_can_fetch;

  // Only the sample bits are ever served, so only they are stored.
  i2s_stream_controller_sync_fifo #(
    .DATA_WIDTH (SAMPLE_WIDTH),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (bus.flush),
    .i_push    (bus.memory_data_strobe),
    .i_wr_data (bus.memory_data[SAMPLE_WIDTH-1:0]),
    .i_pop     (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (w_level)
  );

  assign w_trigger   = bus.audio_data_request && !r_ack && bus.enable;
  assign w_pop       = w_trigger && !w_empty;
  // Outstanding words are always zero in IDLE, so free space alone decides.
  assign w_can_fetch = bus.enable && !bus.flush && ((DEPTH_L - w_level) >= BURST_L);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= FETCH_IDLE;
      r_request_data <= 1'b0;
      r_request_size <= '0;
    end else begin
      r_request_size <= REQ_SIZE_W'(BURST_SIZE);
      case (r_state)
        FETCH_IDLE: if (w_can_fetch) begin
          r_state        <= FETCH_REQ;
          r_request_data <= 1'b1;
        end
        FETCH_REQ: begin
          r_state        <= FETCH_WAIT;
          r_request_data <= 1'b0;
        end
        FETCH_WAIT: if (bus.request_finished) r_state <= FETCH_IDLE;
        default: begin
          r_state        <= FETCH_IDLE;
          r_request_data <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack            <= 1'b0;
      r_audio_data     <= '0;
      r_last_sample    <= '0;
      r_channel        <= '0;
      r_ch_cnt         <= '0;
      r_underrun       <= 1'b0;
      r_overflow       <= 1'b0;
      r_underrun_count <= '0;
    end else begin
      r_underrun <= 1'b0;
      if (bus.memory_data_strobe && !bus.flush && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_trigger) begin
        r_ack     <= 1'b1;
        r_channel <= r_ch_cnt;
        r_ch_cnt  <= (r_ch_cnt == LAST_CH) ? '0 : r_ch_cnt + 1'b1;
        if (!w_empty) begin
          r_audio_data  <= w_head;
          r_last_sample <= w_head;
        end else begin
          r_audio_data <= bus.hold_on_underrun ? r_last_sample : '0;
          r_underrun   <= 1'b1;
          if (r_underrun_count != '1) r_underrun_count <= r_underrun_count + 1'b1;
        end
      end else if (r_ack && !bus.audio_data_request) begin
        r_ack <= 1'b0;
      end
      if (bus.flush) r_ch_cnt <= '0;
    end
  end

  assign bus.request_data   = r_request_data;
  assign bus.request_size   = r_request_size;
  assign bus.audio_data_ack = r_ack;
  assign bus.audio_data     = r_audio_data;
  assign bus.audio_channel  = r_channel;
  assign bus.underrun       = r_underrun;
  assign bus.overflow       = r_overflow;
  assign bus.underrun_count = r_underrun_count;
  assign bus.fifo_level     = w_level;
  assign bus.fetch_state    = r_state;

endmodule

// File: tb/tb_i2s_stream_controller.sv
// Directed bench for i2s_stream_controller: a 2-channel/16-deep instance (A)
// and a 6-channel/4-deep instance (B) driven by hand-computed vectors.
module tb_i2s_stream_controller;
  import i2s_stream_controller_pkg::*;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   req_cnt_a = 0;
  int   req_cnt_b = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  i2s_stream_controller_if #(.DATA_WIDTH(32), .SAMPLE_WIDTH(24), .CHANNELS(2), .FIFO_ADDR_WIDTH(4)) bus_a ();
  i2s_stream_controller_if #(.DATA_WIDTH(32), .SAMPLE_WIDTH(24), .CHANNELS(6), .FIFO_ADDR_WIDTH(2)) bus_b ();

  i2s_stream_controller #(
    .DATA_WIDTH(32), .SAMPLE_WIDTH(24), .CHANNELS(2), .FIFO_ADDR_WIDTH(4), .BURST_SIZE(8)
  ) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a.master));

  i2s_stream_controller #(
    .DATA_WIDTH(32), .SAMPLE_WIDTH(24), .CHANNELS(6), .FIFO_ADDR_WIDTH(2), .BURST_SIZE(4)
  ) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b.master));

  // Request pulses are counted independently so none is missed mid-handshake.
  always @(negedge clk) begin
    if (bus_a.request_data) req_cnt_a++;
    if (bus_b.request_data) req_cnt_b++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_ack(input int which);
    return (which == 0) ? bus_a.audio_data_ack : bus_b.audio_data_ack;
  endfunction

  function automatic logic get_underrun(input int which);
    return (which == 0) ? bus_a.underrun : bus_b.underrun;
  endfunction

  task automatic set_req(input int which, input logic v);
    if (which == 0) bus_a.audio_data_request = v;
    else            bus_b.audio_data_request = v;
  endtask

  task automatic set_strobe(input int which, input logic v, input logic [31:0] word);
    if (which == 0) begin bus_a.memory_data_strobe = v; bus_a.memory_data = word; end
    else            begin bus_b.memory_data_strobe = v; bus_b.memory_data = word; end
  endtask

  // One full 4-phase transfer; optionally strobes a word on the request edge.
  task automatic handshake(input int which, input bit with_strobe, input logic [31:0] word,
                           output logic [23:0] data, output int ch, output int lat, output int urs);
    lat = -1; urs = 0; data = '0; ch = -1;
    set_req(which, 1'b1);
    if (with_strobe) set_strobe(which, 1'b1, word);
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (with_strobe) set_strobe(which, 1'b0, 32'h0);
      if (get_underrun(which)) urs++;
      if (get_ack(which)) begin
        lat  = n;
        data = (which == 0) ? bus_a.audio_data : bus_b.audio_data;
        ch   = (which == 0) ? int'(bus_a.audio_channel) : int'(bus_b.audio_channel);
        break;
      end
    end
    set_req(which, 1'b0);
    for (int n = 0; n < 10 && get_ack(which); n++) begin
      @(posedge clk); #1;
      if (get_underrun(which)) urs++;
    end
    if (get_ack(which)) check("hs_ack_release", 32'(get_ack(which)), 32'h0);
  endtask

  task automatic respond_a(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      bus_a.memory_data_strobe = 1'b1;
      bus_a.memory_data        = base + 32'(i);
      @(posedge clk); #1;
    end
    bus_a.memory_data_strobe = 1'b0;
    bus_a.request_finished   = 1'b1;
    @(posedge clk); #1;
    bus_a.request_finished   = 1'b0;
  endtask

  task automatic wait_req_a(input int target, input string tag);
    for (int n = 0; n < 30 && req_cnt_a < target; n++) begin
      @(posedge clk); #1;
    end
    check(tag, 32'(req_cnt_a >= target), 32'h1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] d;
    logic [31:0] e;
    int ch, lat, urs, c0, acks;

    bus_a.enable = 0; bus_a.flush = 0; bus_a.hold_on_underrun = 0; bus_a.request_finished = 0;
    bus_a.memory_data_strobe = 0; bus_a.memory_data = '0; bus_a.audio_data_request = 0;
    bus_b.enable = 0; bus_b.flush = 0; bus_b.hold_on_underrun = 0; bus_b.request_finished = 0;
    bus_b.memory_data_strobe = 0; bus_b.memory_data = '0; bus_b.audio_data_request = 0;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_req",       32'(bus_a.request_data), 32'h0);
    check("rst_req_size",  32'(bus_a.request_size), 32'h0);
    check("rst_ack",       32'(bus_a.audio_data_ack), 32'h0);
    check("rst_data",      32'(bus_a.audio_data), 32'h0);
    check("rst_level",     32'(bus_a.fifo_level), 32'h0);
    check("rst_overflow",  32'(bus_a.overflow), 32'h0);
    check("rst_ucount",    32'(bus_a.underrun_count), 32'h0);
    check("rst_state",     32'(bus_a.fetch_state), 32'(FETCH_IDLE));

    // Test 1: burst fetch and refetch threshold
    c0 = req_cnt_a;
    rst_a = 1'b0; bus_a.enable = 1'b1;
    wait_req_a(c0 + 1, "t1_req1_seen");
    check("t1_req_size", 32'(bus_a.request_size), 32'd8);
    respond_a(32'h11, 8);
    check("t1_one_pulse", 32'(req_cnt_a), 32'(c0 + 1));
    check("t1_level_8",   32'(bus_a.fifo_level), 32'd8);
    wait_req_a(c0 + 2, "t1_req2_at_level8");
    respond_a(32'h21, 8);
    repeat (6) begin @(posedge clk); #1; end
    check("t1_no_req_full", 32'(req_cnt_a), 32'(c0 + 2));
    check("t1_level_16",    32'(bus_a.fifo_level), 32'd16);

    // Test 2: in-order delivery with alternating channels
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h11 + 32'(i));
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h21 + 32'(i));
    for (int i = 0; i < 16; i++) begin
      handshake(0, 1'b0, 32'h0, d, ch, lat, urs);
      e = exp_q.pop_front();
      check($sformatf("t2_data_%0d", i), 32'(d), e);
      check($sformatf("t2_ch_%0d", i),   32'(ch), 32'(i % 2));
      check($sformatf("t2_lat_%0d", i),  32'(lat), 32'd1);
      check($sformatf("t2_urs_%0d", i),  32'(urs), 32'd0);
      if (i == 7) wait_req_a(c0 + 3, "t2_refetch_at_8");
    end
    check("t2_level_0", 32'(bus_a.fifo_level), 32'h0);

    // Test 3: underrun emits zero, channel keeps framing
    bus_a.hold_on_underrun = 1'b0;
    for (int i = 0; i < 3; i++) begin
      handshake(0, 1'b0, 32'h0, d, ch, lat, urs);
      check($sformatf("t3_data_%0d", i), 32'(d), 32'h0);
      check($sformatf("t3_ch_%0d", i),   32'(ch), 32'(i % 2));
      check($sformatf("t3_urs_%0d", i),  32'(urs), 32'd1);
    end
    check("t3_ucount", 32'(bus_a.underrun_count), 32'd3);

    // Test 4: hold last sample on underrun
    respond_a(32'hFFABCDEF, 1);
    handshake(0, 1'b0, 32'h0, d, ch, lat, urs);
    check("t4_pop_data", 32'(d), 32'h00ABCDEF);
    check("t4_pop_ch",   32'(ch), 32'd1);
    bus_a.hold_on_underrun = 1'b1;
    handshake(0, 1'b0, 32'h0, d, ch, lat, urs);
    check("t4_hold_data", 32'(d), 32'h00ABCDEF);
    check("t4_hold_ch",   32'(ch), 32'd0);
    check("t4_hold_urs",  32'(urs), 32'd1);
    check("t4_ucount",    32'(bus_a.underrun_count), 32'd4);
    repeat (3) begin @(posedge clk); #1; end
    check("t4_data_held", 32'(bus_a.audio_data), 32'h00ABCDEF);

    // Word strobed on the trigger edge of an empty FIFO: underrun, word kept
    bus_a.hold_on_underrun = 1'b0;
    handshake(0, 1'b1, 32'h00000055, d, ch, lat, urs);
    check("same_cyc_data",  32'(d), 32'h0);
    check("same_cyc_urs",   32'(urs), 32'd1);
    check("same_cyc_ch",    32'(ch), 32'd1);
    check("same_cyc_level", 32'(bus_a.fifo_level), 32'd1);
    check("same_cyc_ucnt",  32'(bus_a.underrun_count), 32'd5);

    // enable low blocks new acks
    bus_a.enable = 1'b0; bus_a.audio_data_request = 1'b1; acks = 0;
    repeat (5) begin @(posedge clk); #1; if (bus_a.audio_data_ack) acks++; end
    bus_a.audio_data_request = 1'b0;
    check("en_low_no_ack", 32'(acks), 32'd0);
    check("en_low_level",  32'(bus_a.fifo_level), 32'd1);

    // Test 5: 4-deep FIFO overflow, sticky until reset
    rst_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_strobe(1, 1'b1, 32'hB1 + 32'(i));
      @(posedge clk); #1;
    end
    set_strobe(1, 1'b0, 32'h0);
    check("t5_level_4",  32'(bus_b.fifo_level), 32'd4);
    check("t5_overflow", 32'(bus_b.overflow), 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    check("t5_ovf_sticky", 32'(bus_b.overflow), 32'd1);
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    check("t5_ovf_rst",   32'(bus_b.overflow), 32'd0);
    check("t5_level_rst", 32'(bus_b.fifo_level), 32'd0);
    for (int i = 0; i < 4; i++) begin
      set_strobe(1, 1'b1, 32'hA1 + 32'(i));
      @(posedge clk); #1;
    end
    set_strobe(1, 1'b0, 32'h0);
    check("t5_full_no_ovf", 32'(bus_b.overflow), 32'd0);
    bus_b.enable = 1'b1;
    handshake(1, 1'b1, 32'hA5, d, ch, lat, urs);
    check("t5_pp_data",   32'(d), 32'hA1);
    check("t5_pp_ch",     32'(ch), 32'd0);
    check("t5_pp_no_ovf", 32'(bus_b.overflow), 32'd0);
    check("t5_pp_level",  32'(bus_b.fifo_level), 32'd4);

    // Test 6: 6-channel sequencing, flush, reset during WAIT
    for (int i = 1; i < 4; i++) begin
      handshake(1, 1'b0, 32'h0, d, ch, lat, urs);
      check($sformatf("t6_data_%0d", i), 32'(d), 32'hA1 + 32'(i));
      check($sformatf("t6_ch_%0d", i),   32'(ch), 32'(i));
    end
    check("t6_level_1", 32'(bus_b.fifo_level), 32'd1);
    bus_b.flush = 1'b1;
    set_strobe(1, 1'b1, 32'h99);
    @(posedge clk); #1;
    bus_b.flush = 1'b0;
    set_strobe(1, 1'b0, 32'h0);
    check("t6_flush_level", 32'(bus_b.fifo_level), 32'd0);
    handshake(1, 1'b0, 32'h0, d, ch, lat, urs);
    check("t6_flush_ch",   32'(ch), 32'd0);
    check("t6_flush_data", 32'(d), 32'h0);
    check("t6_flush_urs",  32'(urs), 32'd1);
    check("t6_ucount",     32'(bus_b.underrun_count), 32'd1);
    for (int n = 0; n < 10 && bus_b.fetch_state != FETCH_WAIT; n++) begin
      @(posedge clk); #1;
    end
    check("t6_in_wait", 32'(bus_b.fetch_state), 32'(FETCH_WAIT));
    rst_b = 1'b1; bus_b.enable = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_state",  32'(bus_b.fetch_state), 32'(FETCH_IDLE));
    check("t6_rst_req",    32'(bus_b.request_data), 32'h0);
    check("t6_rst_ack",    32'(bus_b.audio_data_ack), 32'h0);
    check("t6_rst_ch",     32'(bus_b.audio_channel), 32'h0);
    check("t6_rst_urun",   32'(bus_b.underrun), 32'h0);
    check("t6_rst_ucount", 32'(bus_b.underrun_count), 32'h0);
    check("t6_rst_level",  32'(bus_b.fifo_level), 32'h0);
    check("t6_rst_rsize",  32'(bus_b.request_size), 32'h0);
    rst_b = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_stream_controller.md
Name: i2s_stream_controller

Overview:
Single-clock, parametrised successor to the I2S memory controller. It fetches sample words from memory in fixed-size bursts into an internal synchronous FIFO and serves them to an I2S writer over a 4-phase request/ack handshake. It adds:
- N-channel sequencing in place of a single L/R bit.
- Configurable sample width.
- Underrun handling: emit zero, or hold the last sample.
- Overflow and underrun status.

The block sits between the wishbone memory-fetch engine and the I2S serialiser.

Parameters:
DATA_WIDTH, 32, memory word width
SAMPLE_WIDTH, 24, audio sample width; must be <= DATA_WIDTH; sample = memory_data[SAMPLE_WIDTH-1:0]
CHANNELS, 2, channels per frame (1..16)
FIFO_ADDR_WIDTH, 4, FIFO depth = 2**FIFO_ADDR_WIDTH words
BURST_SIZE, 8, words per memory request; must be <= FIFO depth

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  run control
flush  in  1  one-cycle pulse: empty FIFO, clear channel counter
hold_on_underrun  in  1  1 = repeat last sample on underrun, 0 = emit zero
request_data  out  1  one-cycle pulse requesting a burst
request_size  out  24  burst length in words, constant BURST_SIZE
request_finished  in  1  pulse: burst complete
memory_data_strobe  in  1  memory word valid
memory_data  in  DATA_WIDTH  memory word
audio_data_request  in  1  writer requests next sample
audio_data_ack  out  1  sample valid, 4-phase ack
audio_data  out  SAMPLE_WIDTH  sample
audio_channel  out  clog2(CHANNELS) (min 1)  channel index of audio_data
underrun  out  1  one-cycle pulse per underrun ack
overflow  out  1  sticky, set on write to a full FIFO
underrun_count  out  16  saturating underrun counter
fifo_level  out  FIFO_ADDR_WIDTH+1  current occupancy

Behaviour:
- Reset (synchronous): all outputs 0; FIFO empty; fetch FSM in IDLE; channel counter 0; last-sample register 0.
- FIFO writes:
  - A word is written on memory_data_strobe when the FIFO is not full.
  - When full, the word is dropped and overflow is set (held until rst).
  - Push and pop in the same cycle when full is legal and is not an overflow.
- Fetch FSM (IDLE -> REQ -> WAIT -> IDLE):
  - IDLE -> REQ when enable, no flush, and free space >= BURST_SIZE + words outstanding (outstanding = 0 in IDLE).
  - REQ: request_data = 1 for exactly one cycle, then go to WAIT.
  - WAIT: leave for IDLE on request_finished. Strobes arriving in REQ or WAIT are accepted.
  - enable falling in REQ or WAIT does not abort; the FSM completes to IDLE.
  - request_finished in IDLE is ignored.
- Output handshake:
  - Trigger condition: audio_data_request && !audio_data_ack && enable.
  - On the trigger, the next cycle has audio_data_ack = 1 with audio_data and audio_channel valid.
  - If the FIFO is non-empty: pop the head and present its sample; the last-sample register = sample.
  - If the FIFO is empty: underrun. audio_data = last sample if hold_on_underrun, else 0. underrun pulses 1 cycle. underrun_count increments, saturating at 0xFFFF.
  - The acked channel = channel counter. The counter then increments, wrapping from CHANNELS-1 to 0. Underruns advance the channel too, so framing is kept.
  - audio_data_ack deasserts the cycle after audio_data_request is seen low.
  - audio_data and audio_channel hold until the next ack.
  - Emptiness is evaluated on current occupancy. A word strobed in the same cycle as the trigger on an empty FIFO does not satisfy the request: it is an underrun, and the word is stored.
- enable low: no new acks start; an ack in progress completes its 4-phase normally.
- flush:
  - Clears the FIFO and the channel counter on the next edge. Overflow, underrun_count and the last sample are kept.
  - Strobes in the flush cycle are discarded.
  - An outstanding burst still completes and refills the FIFO.
- fifo_level = writes - reads, range 0..2**FIFO_ADDR_WIDTH.

Decomposition:
- Shared package holds:
  - fetch FSM state encoding (IDLE, REQ, WAIT);
  - the channel-width clog2 function;
  - the underrun counter width constant (16).
- Sub-module sync_fifo (DATA_WIDTH, ADDR_WIDTH): single clock, synchronous reset, flush input, registered level output, first-word-fall-through read.

Test Plan:
1. Reset, enable = 1, memory responds to each request with 8 strobed words and then request_finished -> exactly one request_data pulse, request_size = 8, fifo_level = 8, next request issued only when level <= 8.
2. Words 0x00000011..0x00000018 loaded, writer performs 8 handshakes -> audio_data = 0x000011..0x000018, audio_channel = 0,1,0,1,..., each ack one cycle after request, no underrun.
3. Empty FIFO, hold_on_underrun = 0, three requests -> audio_data = 0 each, underrun pulses 3 times, underrun_count = 3, channel continues 0,1,0.
4. Last sample 0xABCDEF, hold_on_underrun = 1, FIFO empty -> audio_data = 0xABCDEF on ack, underrun pulses once.
5. FIFO_ADDR_WIDTH = 2 with memory strobing 6 words -> 4 stored, overflow = 1 and sticky until rst; simultaneous push+pop at full -> overflow not set.
6. CHANNELS = 6, flush after 4 samples -> fifo_level = 0 and the next ack has audio_channel = 0; rst asserted in WAIT -> FSM IDLE, all outputs 0 next cycle.
